simple_cpu_mc: RTL and testbench

- Parametrised multicycle register-file CPU.
- Replaces the fixed 8-bit, two-register, single-memory core with a 4-entry register file and split instruction/data memory ports.
- Both ports use a req/ack handshake, so wait-state memories and the bus fabric can sit behind it.
- Adds SUB/AND/OR, load-immediate, branch-if-zero and HALT, plus a retire strobe and a register debug read port for the verification bench.

---
 rtl/simple_cpu_mc_if.sv | 21 ++
 rtl/simple_cpu_mc.sv | 95 +++++++++
 tb/tb_simple_cpu_mc.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_cpu_mc_if.sv
// simple_cpu_mc_if: instruction and data memory req/ack buses of simple_cpu_mc
interface simple_cpu_mc_if #(parameter int DW = 8, parameter int AW = 8);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/simple_cpu_mc.sv
// simple_cpu_mc: multicycle 4-register CPU with req/ack instruction and data memory ports
module simple_cpu_mc #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            reset,
    simple_cpu_mc_if.master bus,
    output logic [AW-1:0]   pc,
    output logic            halted,
    output logic            retire,
    input  logic [1:0]      dbg_sel,
    output logic [DW-1:0]   dbg_data
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;
    localparam logic [3:0] OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3, OP_JUMP = 4'h4,
                           OP_SUB = 4'h5, OP_LDI = 4'h6, OP_BEQZ = 4'h7, OP_AND = 4'h8,
                           OP_OR = 4'h9, OP_HALT = 4'hF;
    state_t        state;
    logic [15:0]   ir;
    logic [DW-1:0] r [4];
    logic [3:0]    op;
    logic [1:0]    rd, rs;
    logic [7:0]    imm;
    logic [DW-1:0] alu;
    logic          wr, taken;
    assign {op, rd, rs, imm} = ir;
    assign bus.imem_addr = pc;
    assign dbg_data = r[dbg_sel];
    assign alu = op == OP_ADD ? r[rd] + r[rs] :
                 op == OP_SUB ? r[rd] - r[rs] :
                 op == OP_AND ? r[rd] & r[rs] :
                 op == OP_OR  ? r[rd] | r[rs] : DW'(imm);
    assign wr = op inside {OP_ADD, OP_SUB, OP_LDI, OP_AND, OP_OR};
    assign taken = op == OP_JUMP || (op == OP_BEQZ && r[rs] == '0);
    // req is raised on the edge that enters FETCH/MEM, so after reset FETCH spends one idle cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH;
            pc             <= '0;
            ir             <= '0;
            r              <= '{default: '0};
            halted         <= 1'b0;
            retire         <= 1'b0;
            bus.imem_req   <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus.imem_req && bus.imem_ack) begin
                        ir           <= bus.imem_rdata;
                        bus.imem_req <= 1'b0;
                        state        <= EXEC;
                    end else begin
                        bus.imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    if (op == OP_LOAD || op == OP_STORE) begin
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= op == OP_STORE;
                        bus.dmem_addr  <= AW'(imm);
                        bus.dmem_wdata <= r[rs];
                        state          <= MEM;
                    end else if (op == OP_HALT) begin
                        halted <= 1'b1;
                        retire <= 1'b1;
                        state  <= HALTED;
                    end else begin
                        if (wr) r[rd] <= alu;
                        pc           <= taken ? AW'(imm) : pc + AW'(1);
                        retire       <= 1'b1;
                        bus.imem_req <= 1'b1;
                        state        <= FETCH;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        if (!bus.dmem_we) r[rd] <= bus.dmem_rdata;
                        bus.dmem_req <= 1'b0;
                        pc           <= pc + AW'(1);
                        retire       <= 1'b1;
                        bus.imem_req <= 1'b1;
                        state        <= FETCH;
                    end
                end
                HALTED: ;
            endcase
        end
    end
endmodule

// File: tb/tb_simple_cpu_mc.sv
// tb_simple_cpu_mc: vector table, directed multicycle sequences and a random program against an ISA model
module tb_simple_cpu_mc;
    localparam int DW = 8, AW = 8;
    logic          clk = 1'b0, reset = 1'b1;
    logic [1:0]    dbg_sel = 2'd0;
    logic [AW-1:0] pc;
    logic          halted, retire;
    logic [DW-1:0] dbg_data;
    int            n_cmp = 0, n_bad = 0, cyc = 0;
    simple_cpu_mc_if #(.DW(DW), .AW(AW)) bus ();
    simple_cpu_mc #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .pc(pc), .halted(halted),
        .retire(retire), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    int          iw_lo = 0, iw_hi = 0, dw_lo = 0, dw_hi = 0, icnt = 0, dcnt = 0, iw = 0, dw = 0;
    bit          force_dack = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory responder: ack after a chosen number of wait cycles, sampled by the DUT on the next posedge
    always @(negedge clk) begin
        if (reset || !bus.imem_req) begin
            icnt = 0;
            iw = $urandom_range(iw_hi, iw_lo);
            bus.imem_ack = 1'b0;
        end else begin
            bus.imem_ack = icnt >= iw;
            bus.imem_rdata = imem[bus.imem_addr];
            icnt++;
        end
        if (reset || !bus.dmem_req) begin
            dcnt = 0;
            dw = $urandom_range(dw_hi, dw_lo);
            bus.dmem_ack = force_dack;
        end else begin
            bus.dmem_ack = dcnt >= dw;
            bus.dmem_rdata = dmem[bus.dmem_addr];
            if (bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
            dcnt++;
        end
    end

    int           reqlen = 0;
    logic [AW-1:0] a0;
    logic [DW-1:0] w0;
    logic         we0;
    int           lenlog[$];
    int           welog[$];
    always @(negedge clk) begin
        #1;
        if (bus.dmem_req) begin
            if (reqlen == 0) begin
                a0 = bus.dmem_addr;
                w0 = bus.dmem_wdata;
                we0 = bus.dmem_we;
            end else begin
                chk("dmem_hold", {15'd0, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, {15'd0, we0, a0, w0});
            end
            reqlen++;
            if (bus.dmem_ack) begin
                lenlog.push_back(reqlen);
                welog.push_back(int'(we0));
                reqlen = 0;
            end
        end else begin
            reqlen = 0;
        end
    end

    function automatic logic [15:0] ins(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    task automatic clear_prog();
        foreach (imem[i]) imem[i] = 16'hF000;
    endtask

    task automatic start();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_retire(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (retire) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no retire within 100 cycles", name);
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (halted) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: not halted within 500 cycles", name);
    endtask

    task automatic chk_reg(input string name, input int i, input logic [7:0] exp);
        dbg_sel = 2'(i);
        #1;
        chk($sformatf("%s_r%0d", name, i), {24'd0, dbg_data}, {24'd0, exp});
    endtask

    // asserts reset mid-cycle and checks every reset value before any clock edge
    task automatic chk_reset_state();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_pc", {24'd0, pc}, 0);
        chk("rst_imem_req", {31'd0, bus.imem_req}, 0);
        chk("rst_dmem_req", {31'd0, bus.dmem_req}, 0);
        chk("rst_dmem_we", {31'd0, bus.dmem_we}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_retire", {31'd0, retire}, 0);
        chk("rst_dmem_addr", {24'd0, bus.dmem_addr}, 0);
        chk("rst_dmem_wdata", {24'd0, bus.dmem_wdata}, 0);
        for (int i = 0; i < 4; i++) chk_reg("rst", i, 8'h00);
    endtask

    logic [7:0] m_r [4];
    logic [7:0] m_d [256];
    logic [7:0] m_pc;

    // ISA-level reference: one whole instruction per call
    task automatic model_step();
        logic [15:0] w;
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [7:0]  imm, nx;
        w = imem[m_pc];
        op = w[15:12];
        rd = w[11:10];
        rs = w[9:8];
        imm = w[7:0];
        nx = m_pc + 8'd1;
        case (op)
            4'h1: m_r[rd] = m_d[imm];
            4'h2: m_d[imm] = m_r[rs];
            4'h3: m_r[rd] = m_r[rd] + m_r[rs];
            4'h4: nx = imm;
            4'h5: m_r[rd] = m_r[rd] - m_r[rs];
            4'h6: m_r[rd] = imm;
            4'h7: if (m_r[rs] == 8'd0) nx = imm;
            4'h8: m_r[rd] = m_r[rd] & m_r[rs];
            4'h9: m_r[rd] = m_r[rd] | m_r[rs];
            4'hF: nx = m_pc;
            default: ;
        endcase
        m_pc = nx;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, exp;
        string      name;
    } vec_t;

    initial begin
        vec_t vt[10];
        int   t[3];
        int   viol, found, diffs;
        logic [7:0] bpc[7];
        vt[0] = '{4'h3, 8'h05, 8'h03, 8'h08, "v_add"};
        vt[1] = '{4'h3, 8'hFF, 8'h02, 8'h01, "v_add_wrap"};
        vt[2] = '{4'h5, 8'h03, 8'h05, 8'hFE, "v_sub_borrow"};
        vt[3] = '{4'h5, 8'h10, 8'h10, 8'h00, "v_sub_zero"};
        vt[4] = '{4'h8, 8'hF0, 8'h3C, 8'h30, "v_and"};
        vt[5] = '{4'h9, 8'hF0, 8'h0F, 8'hFF, "v_or"};
        vt[6] = '{4'h6, 8'h99, 8'h44, 8'h00, "v_ldi_imm0"};
        vt[7] = '{4'h0, 8'h5A, 8'h11, 8'h5A, "v_nop"};
        vt[8] = '{4'hA, 8'h12, 8'h34, 8'h12, "v_undef_a"};
        vt[9] = '{4'hE, 8'h77, 8'h01, 8'h77, "v_undef_e"};
        foreach (dmem[i]) dmem[i] = 8'h00;

        // zero-wait ALU sequence and retire spacing
        clear_prog();
        imem[0] = ins(6, 1, 0, 5);
        imem[1] = ins(6, 2, 0, 3);
        imem[2] = ins(3, 1, 2, 0);
        start();
        for (int k = 0; k < 3; k++) begin
            wait_retire("alu_seq");
            t[k] = cyc;
        end
        chk("retire_gap1", t[1] - t[0], 2);
        chk("retire_gap2", t[2] - t[1], 2);
        chk("alu_seq_pc", {24'd0, pc}, 3);
        chk_reg("alu_seq", 1, 8'h08);
        chk_reg("alu_seq", 2, 8'h03);
        wait_halt("alu_seq");
        chk("alu_seq_halted", {31'd0, halted}, 1);
        chk_reset_state();

        foreach (vt[i]) begin
            clear_prog();
            imem[0] = ins(6, 1, 0, vt[i].a);
            imem[1] = ins(6, 2, 0, vt[i].b);
            imem[2] = ins(vt[i].op, 1, 2, 0);
            start();
            wait_halt(vt[i].name);
            chk_reg(vt[i].name, 1, vt[i].exp);
            chk_reg(vt[i].name, 2, vt[i].b);
            chk({vt[i].name, "_pc"}, {24'd0, pc}, 3);
        end

        // store then load with two data wait cycles
        clear_prog();
        imem[0] = ins(6, 0, 0, 8'h10);
        imem[1] = ins(2, 0, 0, 8'h20);
        imem[2] = ins(1, 3, 0, 8'h20);
        dw_lo = 2;
        dw_hi = 2;
        lenlog.delete();
        welog.delete();
        start();
        wait_halt("mem_seq");
        chk("mem_count", lenlog.size(), 2);
        chk("store_req_len", lenlog.size() > 0 ? lenlog[0] : 0, 3);
        chk("load_req_len", lenlog.size() > 1 ? lenlog[1] : 0, 3);
        chk("store_we", welog.size() > 0 ? welog[0] : 9, 1);
        chk("load_we", welog.size() > 1 ? welog[1] : 9, 0);
        chk_reg("mem_seq", 3, 8'h10);
        chk("mem_stored", {24'd0, dmem[8'h20]}, 8'h10);
        chk("mem_seq_pc", {24'd0, pc}, 3);
        dw_lo = 0;
        dw_hi = 0;

        // DW-wide wrap of ADD and SUB
        clear_prog();
        imem[0] = ins(6, 1, 0, 8'hFF);
        imem[1] = ins(6, 2, 0, 2);
        imem[2] = ins(3, 1, 2, 0);
        imem[3] = ins(5, 2, 1, 0);
        imem[4] = ins(5, 2, 1, 0);
        start();
        wait_halt("wrap_seq");
        chk_reg("wrap_seq", 1, 8'h01);
        chk_reg("wrap_seq", 2, 8'h00);
        chk("wrap_seq_pc", {24'd0, pc}, 5);

        // branches, jump and pc wrap, then halt
        clear_prog();
        imem[8'h00] = ins(7, 0, 0, 8'h40);
        imem[8'h40] = ins(6, 0, 0, 1);
        imem[8'h41] = ins(7, 0, 0, 8'h80);
        imem[8'h42] = ins(4, 0, 0, 8'hFF);
        imem[8'hFF] = ins(0, 0, 0, 0);
        imem[8'h01] = 16'hF000;
        bpc = '{8'h40, 8'h41, 8'h42, 8'hFF, 8'h00, 8'h01, 8'h01};
        start();
        foreach (bpc[i]) begin
            wait_retire("branch_seq");
            chk($sformatf("branch_pc%0d", i), {24'd0, pc}, {24'd0, bpc[i]});
        end
        chk("branch_halted", {31'd0, halted}, 1);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            viol += int'(bus.imem_req || bus.dmem_req || retire || pc != 8'h01 || !halted);
        end
        chk("halt_quiet", viol, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("halt_rst_pc", {24'd0, pc}, 0);
        chk("halt_rst_halted", {31'd0, halted}, 0);
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 4 && found == 0; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == 8'h00) found = 1;
        end
        chk("halt_refetch", found, 1);

        // reset in the middle of a stalled load, then a stray ack
        clear_prog();
        imem[0] = ins(1, 3, 0, 5);
        dmem[5] = 8'h77;
        dw_lo = 10;
        dw_hi = 10;
        start();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (bus.dmem_req) found = 1;
        end
        chk("abort_req_seen", found, 1);
        chk_reset_state();
        force_dack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_refetch_req", {31'd0, bus.imem_req}, 1);
        chk("abort_refetch_addr", {24'd0, bus.imem_addr}, 0);
        @(negedge clk);
        force_dack = 1'b0;
        chk_reg("abort", 3, 8'h00);
        wait_retire("abort_reload");
        chk_reg("abort_reload", 3, 8'h77);
        dw_lo = 0;
        dw_hi = 0;

        // random programs with random wait states against the ISA model
        iw_lo = 0;
        iw_hi = 2;
        dw_lo = 0;
        dw_hi = 3;
        for (int rnd = 0; rnd < 2; rnd++) begin
            foreach (imem[i]) imem[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
            foreach (dmem[i]) begin
                dmem[i] = 8'($urandom);
                m_d[i] = dmem[i];
            end
            m_pc = 8'h00;
            foreach (m_r[i]) m_r[i] = 8'h00;
            start();
            for (int k = 0; k < 150; k++) begin
                wait_retire("rnd");
                model_step();
                chk("rnd_pc", {24'd0, pc}, {24'd0, m_pc});
                for (int j = 0; j < 4; j++) chk_reg("rnd", j, m_r[j]);
            end
            diffs = 0;
            foreach (dmem[i]) diffs += int'(dmem[i] != m_d[i]);
            chk("rnd_dmem", diffs, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
